ov7670_config_seq: RTL and testbench
====================================

// Module: ov7670_config_seq
// PURPOSE
//  Walks the OV7670 configuration ROM from address 0 and decodes each 16-bit entry.
//  Each entry {reg[15:8], data[7:0]} becomes one register write, handed to the SCCB
//  master over a valid/ready handshake.
//  Entry 16'hFFF0 inserts a fixed delay; entry 16'hFFFF ends the sequence.
//  Sits between the config ROM (addr in, registered dout, 1-cycle latency) and the SCCB master.
// PARAMETERS
//  DELAY_CYCLES  500_000  clk cycles spent in DELAY per FFF0 entry (10 ms @ 50 MHz); >= 1
//  DELAY_W       20       width of delay counter; must hold DELAY_CYCLES
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous active-low reset
//  start       in   1   1-cycle pulse: begin sequence from addr 0 (honoured in IDLE or DONE only)
//  rom_addr    out  8   address to config ROM
//  rom_dout    in   16  ROM data, valid the cycle after rom_addr is presented
//  sccb_valid  out  1   register write request
//  sccb_ready  in   1   SCCB master accepts request
//  sccb_reg    out  8   SCCB register address
//  sccb_data   out  8   SCCB register value
//  busy        out  1   high in any state other than IDLE/DONE
//  done        out  1   high in DONE; cleared by start or reset
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; rom_addr=0, sccb_valid=0, sccb_reg=0, sccb_data=0, busy=0, done=0.
//   - Delay counter cleared. Applies mid-transaction too; no partial request survives.
//  All outputs are registered; sccb_valid never depends combinationally on sccb_ready.
//  IDLE:
//   - start=1 -> FETCH, rom_addr=0.
//  FETCH (1 cycle):
//   - rom_addr stable; ROM latches it -> DECODE.
//  DECODE (1 cycle), sampling rom_dout:
//   - 16'hFFFF -> DONE.
//   - 16'hFFF0 -> DELAY, counter=0.
//   - otherwise: sccb_reg=rom_dout[15:8], sccb_data=rom_dout[7:0], sccb_valid=1 -> SEND.
//  SEND:
//   - Hold sccb_valid/sccb_reg/sccb_data stable until a clk edge with sccb_valid && sccb_ready.
//   - On that edge: sccb_valid=0, then advance (below).
//  DELAY:
//   - Counter increments each cycle; after exactly DELAY_CYCLES cycles in DELAY, advance.
//   - sccb_valid stays 0 throughout.
//  Advance:
//   - rom_addr<255 -> rom_addr+1, FETCH.
//   - rom_addr==255 -> DONE (no wrap; 256-entry cap).
//  DONE:
//   - done=1, busy=0.
//   - start -> done=0, rom_addr=0, FETCH.
//  start is ignored in FETCH/DECODE/SEND/DELAY.
//  Latency:
//   - start in cycle 0 -> FETCH cycle 1, DECODE cycle 2, sccb_valid=1 in cycle 3.
//   - Handshake at edge ending cycle k -> next sccb_valid in cycle k+3.
//  FFF0 at entry 0 is legal; back-to-back FFF0 entries give back-to-back delays.
// TESTING
//  1. Assert rst_n=0 mid-run -> all outputs 0 immediately (async); rom_addr=0, state IDLE.
//  2. ROM = camera table, DELAY_CYCLES=16, ready tied 1, start pulse ->
//     write 12/80, then exactly 16 cycles with valid=0, then writes 12/04, 11/9F, ...
//     -> done after the first FFFF entry.
//  3. ROM entry 12/04, sccb_ready held low 5 cycles after valid ->
//     valid, reg=12, data=04 stable all 5 cycles; exactly one handshake counted.
//  4. ROM {AA/55, BB/66, CC/77, FFFF} -> exactly 3 writes in order;
//     done=1, busy=0 with rom_addr=3; start again -> identical replay.
//  5. rst_n pulse during DELAY, then start -> sequence restarts at rom_addr 0
//     with full delay; start pulses while busy have no effect.
//  6. ROM with no FFFF (256 ordinary entries) -> 256 writes (addr 0..255), then DONE; rom_addr never wraps to 0.

Source files
------------

// File: rtl/ov7670_config_seq.sv
// OV7670 configuration sequencer: walks the config ROM from address 0,
// turns each {reg,data} entry into one SCCB write request, inserts a fixed
// delay on 16'hFFF0 and stops on 16'hFFFF or after entry 255.
module ov7670_config_seq #(
  parameter int DELAY_CYCLES = 500_000,
  parameter int DELAY_W      = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_dout,
  output logic        sccb_valid,
  input  logic        sccb_ready,
  output logic [7:0]  sccb_reg,
  output logic [7:0]  sccb_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, SEND, DELAY, DONE
  } state_t;

  localparam logic [DELAY_W-1:0] CNT_LAST = DELAY_W'(DELAY_CYCLES - 1);

  state_t             state;
  logic [DELAY_W-1:0] cnt;
  logic               adv;

  // Current entry finished: write accepted, or last delay cycle reached.
  assign adv = ((state == SEND) && sccb_ready) ||
               ((state == DELAY) && (cnt == CNT_LAST));

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rom_addr   <= 8'd0;
      sccb_valid <= 1'b0;
      sccb_reg   <= 8'd0;
      sccb_data  <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= FETCH;
            rom_addr <= 8'd0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          if (rom_dout == 16'hFFFF) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (rom_dout == 16'hFFF0) begin
            state <= DELAY;
            cnt   <= '0;
          end else begin
            sccb_reg   <= rom_dout[15:8];
            sccb_data  <= rom_dout[7:0];
            sccb_valid <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (sccb_ready) sccb_valid <= 1'b0;
        end
        DELAY: begin
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase

      // Move to the next entry; the ROM is capped at 256 entries, no wrap.
      if (adv) begin
        if (rom_addr == 8'hFF) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          rom_addr <= rom_addr + 8'd1;
          state    <= FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Directed bench for ov7670_config_seq with a registered ROM model and a
// write scoreboard fed from the ROM contents and drained on each handshake.
module tb_ov7670_config_seq;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_dout = 16'h0000;
  logic        sccb_valid;
  logic        sccb_ready = 1'b0;
  logic [7:0]  sccb_reg;
  logic [7:0]  sccb_data;
  logic        busy;
  logic        done;

  ov7670_config_seq #(.DELAY_CYCLES(N), .DELAY_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout),
    .sccb_valid (sccb_valid),
    .sccb_ready (sccb_ready),
    .sccb_reg   (sccb_reg),
    .sccb_data  (sccb_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [15:0] rom_mem [256];
  logic [15:0] exp_q [$];
  int          vstart [$];
  int          cyc = 0;
  int          hs_count = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        prev_v = 1'b0;

  // Registered ROM, one cycle of latency.
  always @(posedge clk) rom_dout <= rom_mem[rom_addr];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: record valid rising cycles and score each accepted write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sccb_valid && !prev_v) vstart.push_back(cyc);
      prev_v = sccb_valid;
      if (sccb_valid && sccb_ready) begin
        hs_count++;
        if (exp_q.size() == 0) chk("unexpected_write", {16'h0, sccb_reg, sccb_data}, 32'hFFFF_FFFF);
        else chk("write", {16'h0, sccb_reg, sccb_data}, {16'h0, exp_q.pop_front()});
      end
    end else begin
      prev_v = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    for (int i = 0; i < lim && !done; i++) tick();
    chk(tag, {31'h0, done}, 32'd1);
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
  endtask

  int s, h0;

  initial begin
    rom_clear();
    // Reset state
    repeat (3) tick();
    chk("rst_valid", {31'h0, sccb_valid}, 32'd0);
    chk("rst_addr",  {24'h0, rom_addr}, 32'd0);
    chk("rst_reg",   {24'h0, sccb_reg}, 32'd0);
    chk("rst_data",  {24'h0, sccb_data}, 32'd0);
    chk("rst_busy",  {31'h0, busy}, 32'd0);
    chk("rst_done",  {31'h0, done}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Camera table with a delay entry, ready tied high
    rom_mem[0] = 16'h1280; rom_mem[1] = 16'hFFF0; rom_mem[2] = 16'h1204;
    rom_mem[3] = 16'h119F; rom_mem[4] = 16'hFFFF; rom_mem[5] = 16'h1234;
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1204); exp_q.push_back(16'h119F);
    sccb_ready = 1'b1;
    vstart.delete();
    h0 = hs_count;
    pulse_start(s);
    chk("t2_busy", {31'h0, busy}, 32'd1);
    wait_done("t2_done", 200);
    chk("t2_hs", hs_count - h0, 32'd3);
    chk("t2_busy_end", {31'h0, busy}, 32'd0);
    chk("t2_addr", {24'h0, rom_addr}, 32'd4);
    chk("t2_nvalid", vstart.size(), 32'd3);
    if (vstart.size() >= 3) begin
      chk("t2_first_lat", vstart[0] - s, 32'd3);
      chk("t2_delay_gap", vstart[1] - vstart[0], N + 5);
      chk("t2_back2back", vstart[2] - vstart[1], 32'd3);
    end
    chk("t2_sb_empty", exp_q.size(), 32'd0);

    // Backpressure: ready low for 5 valid cycles
    rom_clear();
    rom_mem[0] = 16'h1204;
    exp_q.push_back(16'h1204);
    sccb_ready = 1'b0;
    h0 = hs_count;
    pulse_start(s);
    for (int i = 0; i < 10 && !sccb_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", {31'h0, sccb_valid}, 32'd1);
      chk("t3_hold_rd", {16'h0, sccb_reg, sccb_data}, 32'h1204);
      tick();
    end
    sccb_ready = 1'b1;
    tick();
    sccb_ready = 1'b0;
    chk("t3_valid_drop", {31'h0, sccb_valid}, 32'd0);
    wait_done("t3_done", 50);
    chk("t3_hs", hs_count - h0, 32'd1);

    // Short table, then replay
    rom_clear();
    rom_mem[0] = 16'hAA55; rom_mem[1] = 16'hBB66; rom_mem[2] = 16'hCC77;
    sccb_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(16'hAA55); exp_q.push_back(16'hBB66); exp_q.push_back(16'hCC77);
      h0 = hs_count;
      pulse_start(s);
      chk("t4_done_clr", {31'h0, done}, 32'd0);
      wait_done("t4_done", 100);
      chk("t4_hs", hs_count - h0, 32'd3);
      chk("t4_busy", {31'h0, busy}, 32'd0);
      chk("t4_addr", {24'h0, rom_addr}, 32'd3);
    end

    // Reset in DELAY, restart with full delay; start while busy ignored
    rom_clear();
    rom_mem[0] = 16'hFFF0; rom_mem[1] = 16'h1234;
    pulse_start(s);
    repeat (6) tick();
    pulse_start(s);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'h0, sccb_valid}, 32'd0);
    chk("t5_rst_busy",  {31'h0, busy}, 32'd0);
    chk("t5_rst_done",  {31'h0, done}, 32'd0);
    chk("t5_rst_addr",  {24'h0, rom_addr}, 32'd0);
    chk("t5_rst_rd",    {16'h0, sccb_reg, sccb_data}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back(16'h1234);
    vstart.delete();
    h0 = hs_count;
    pulse_start(s);
    repeat (8) tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 60 && vstart.size() == 0; i++) tick();
    chk("t5_nvalid", vstart.size(), 32'd1);
    if (vstart.size() >= 1) chk("t5_lat", vstart[0] - s, N + 5);
    wait_done("t5_done", 60);
    chk("t5_hs", hs_count - h0, 32'd1);

    // 256 ordinary entries, no terminator
    for (int i = 0; i < 256; i++) begin
      rom_mem[i] = {i[7:0], ~i[7:0]};
      exp_q.push_back({i[7:0], ~i[7:0]});
    end
    h0 = hs_count;
    pulse_start(s);
    wait_done("t6_done", 1000);
    chk("t6_hs", hs_count - h0, 32'd256);
    chk("t6_addr", {24'h0, rom_addr}, 32'd255);
    chk("t6_busy", {31'h0, busy}, 32'd0);
    repeat (5) tick();
    chk("t6_no_wrap", {24'h0, rom_addr}, 32'd255);
    chk("t6_sb_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
